quadrature_decoder: RTL

//   Converts two raw quadrature inputs (A/B) into count-enable and direction strobes.

---
 rtl/quadrature_decoder.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/quadrature_decoder.sv
// x4 quadrature decoder: 2-FF sync and glitch filter per channel, then Gray-code step
// decode into registered en/up strobes, with err pulses and a saturating error count.
//
// state  | meaning
// S_INIT | let sync/filter settle for FILT_LEN+3 cycles, then adopt current phase silently
// S_RUN  | compare filtered {A,B} against last phase every cycle, emit en/up or err
module quadrature_decoder #(
  parameter int unsigned FILT_LEN = 4,
  parameter int unsigned ERR_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_in,
  input  logic             b_in,
  output logic             en,
  output logic             up,
  output logic             err,
  output logic [ERR_W-1:0] err_cnt
);

  localparam logic [7:0] FCNT_TC = 8'(FILT_LEN - 1);
  localparam logic [8:0] INIT_TC = 9'(FILT_LEN + 2);

  typedef enum logic {S_INIT, S_RUN} state_t;

  // Bit 1 is channel A, bit 0 is channel B throughout.
  logic [1:0]      sync1_q, sync2_q;
  logic [1:0]      filt_q, filt_d;
  logic [1:0][7:0] fcnt_q, fcnt_d;

  state_t          state_q, state_d;
  logic [8:0]      init_cnt_q, init_cnt_d;
  logic [1:0]      phase_q, phase_d;

  logic             en_q, en_d;
  logic             up_q, up_d;
  logic             err_q, err_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      filt_q  <= '0;
      fcnt_q  <= '0;
    end else begin
      sync1_q <= {a_in, b_in};
      sync2_q <= sync1_q;
      filt_q  <= filt_d;
      fcnt_q  <= fcnt_d;
    end
  end

  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] != filt_q[i]) begin
        if (fcnt_q[i] == FCNT_TC) begin
          filt_d[i] = sync2_q[i];
        end else begin
          fcnt_d[i] = fcnt_q[i] + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_INIT;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (state_q == S_INIT && init_cnt_q == INIT_TC) begin
      state_d = S_RUN;
    end
  end

  always_comb begin
    init_cnt_d = '0;
    phase_d    = phase_q;
    en_d       = 1'b0;
    up_d       = up_q;
    err_d      = 1'b0;
    err_cnt_d  = err_cnt_q;
    case (state_q)
      S_INIT: begin
        if (init_cnt_q == INIT_TC) begin
          phase_d = filt_q;
        end else begin
          init_cnt_d = init_cnt_q + 9'd1;
        end
      end
      S_RUN: begin
        phase_d = filt_q;
        case ({phase_q, filt_q})
          4'b0010, 4'b1011, 4'b1101, 4'b0100: begin
            en_d = 1'b1;
            up_d = 1'b1;
          end
          4'b0001, 4'b0111, 4'b1110, 4'b1000: begin
            en_d = 1'b1;
            up_d = 1'b0;
          end
          4'b0011, 4'b1100, 4'b0110, 4'b1001: begin
            err_d = 1'b1;
            if (err_cnt_q != '1) begin
              err_cnt_d = err_cnt_q + 1'b1;
            end
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      phase_q   <= '0;
      en_q      <= 1'b0;
      up_q      <= 1'b1;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      phase_q   <= phase_d;
      en_q      <= en_d;
      up_q      <= up_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign en      = en_q;
  assign up      = up_q;
  assign err     = err_q;
  assign err_cnt = err_cnt_q;

endmodule
